// File: rtl/squeezer_rule_pipe.sv
// rtl/squeezer_rule_pipe.sv - two-stage multi-lane squeezer rule decoder with saturating rule counters
module squeezer_rule_pipe #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*LANES-1:0]   in_p,
    input  logic [2*LANES-1:0]   in_q,
    input  logic [LANES-1:0]     in_r2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3*LANES-1:0]   out_rule,
    output logic [2*LANES-1:0]   out_p,
    output logic [2*LANES-1:0]   out_q,
    input  logic [2:0]           cnt_sel,
    output logic [CNT_W-1:0]     cnt_value,
    input  logic                 cnt_clear
);
    localparam int IW = $clog2(LANES + 1);
    localparam int SW = CNT_W + IW;

    logic                 s1_valid, s2_valid;
    logic                 s1_adv, s2_adv;
    logic [2*LANES-1:0]   s1_p, s1_q, s2_p, s2_q;
    logic [LANES-1:0]     s1_r2;
    logic [3*LANES-1:0]   s2_rule, rule_next;
    logic [CNT_W-1:0]     cnt      [6];
    logic [CNT_W-1:0]     cnt_next [6];
    logic [IW-1:0]        hits     [6];
    logic [SW-1:0]        sum      [6];

    function automatic logic [2:0] squeeze_rule(input logic [1:0] p0, input logic [1:0] q0,
                                                input logic r2);
        if (!p0[1])
            return 3'd1;
        else if (q0[0])
            return 3'd2;
        else if (!r2)
            return p0[0] ? 3'd3 : 3'd4;
        else
            return p0[0] ? 3'd0 : 3'd5;
    endfunction

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;
    assign out_rule  = s2_rule;
    assign out_p     = s2_p;
    assign out_q     = s2_q;

    always_comb begin
        rule_next = '0;
        for (int k = 0; k < LANES; k++)
            rule_next[3*k +: 3] = squeeze_rule(s1_p[2*k +: 2], s1_q[2*k +: 2], s1_r2[k]);
    end

    // Top-up happens on entry so S1 already holds the normalised pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_p     <= '0;
            s1_q     <= '0;
            s1_r2    <= '0;
            s2_p     <= '0;
            s2_q     <= '0;
            s2_rule  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_p  <= in_p | in_q;
                    s1_q  <= in_p & in_q;
                    s1_r2 <= in_r2;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_rule <= rule_next;
                    s2_p    <= s1_p;
                    s2_q    <= s1_q;
                end
            end
        end
    end

    // Per-rule lane hit counts of the beat in S2, then a widened add that clamps at all-ones.
    always_comb begin
        for (int r = 0; r < 6; r++) begin
            hits[r] = '0;
            for (int k = 0; k < LANES; k++)
                if (s2_rule[3*k +: 3] == 3'(r))
                    hits[r] = hits[r] + 1'b1;
            sum[r] = SW'(cnt[r]) + SW'(hits[r]);
            cnt_next[r] = (sum[r] > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[r][CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            for (int r = 0; r < 6; r++)
                cnt[r] <= '0;
        end else if (s2_valid && out_ready) begin
            for (int r = 0; r < 6; r++)
                cnt[r] <= cnt_next[r];
        end
    end

    always_comb begin
        cnt_value = '0;
        for (int r = 0; r < 6; r++)
            if (cnt_sel == 3'(r))
                cnt_value = cnt[r];
    end
endmodule
